// File: rtl/fft_frame_feeder_if.sv
// Sample-in / complex-word-out bundle of the FFT frame feeder.
// Handshake: a beat moves on a rising edge where valid && ready; a source never drops valid or changes data before that beat.
interface fft_frame_feeder_if;
  logic [15:0] i_sample;
  logic        i_sample_valid;
  logic        o_sample_ready;
  logic        i_flush;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic        o_last;
  logic        o_frame_done;
  logic        o_busy;

  modport master (
    input  i_sample, i_sample_valid, i_flush, i_data_ready,
    output o_sample_ready, o_data, o_data_valid, o_last, o_frame_done, o_busy
  );

  modport slave (
    output i_sample, i_sample_valid, i_flush, i_data_ready,
    input  o_sample_ready, o_data, o_data_valid, o_last, o_frame_done, o_busy
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Buffers real samples, packs them as {16'h0, sample} and streams FRAME_LEN-word frames to the FFT.
// Define FFT_FEEDER_PAD_EN to build the flush flag and the zero-padding PAD state.
module fft_frame_feeder #(
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  fft_frame_feeder_if.master  io_bus,
  output logic [1:0]          o_dbg_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

`ifdef FFT_FEEDER_PAD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_PAD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1} state_t;
`endif

  state_t        r_state;
  state_t        w_state_nxt;

  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [31:0]   r_data;
  logic          r_valid;
  logic          r_last;
  logic          r_frame_done;
  logic [IW-1:0] r_idx;

  logic          w_empty;
  logic          w_full;
  logic          w_wr;
  logic          w_rd;
  logic          w_xfer;
  logic          w_out_free;
  logic          w_load;
  logic [31:0]   w_load_word;
  logic [IW-1:0] w_load_idx;
  logic          w_sample_ready;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr       = io_bus.i_sample_valid & w_sample_ready;
  assign w_xfer     = r_valid & io_bus.i_data_ready;
  assign w_out_free = ~r_valid | w_xfer;
  // A word loaded in the same cycle the current one leaves belongs to the next index.
  assign w_load_idx = w_xfer ? (r_idx + IW'(1)) : r_idx;

`ifdef FFT_FEEDER_PAD_EN
  logic r_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flush <= 1'b0;
    end else if ((w_state_nxt == S_IDLE) && (r_state != S_IDLE)) begin
      r_flush <= 1'b0;
    end else if (io_bus.i_flush && ((r_idx != '0) || !w_empty || r_valid)) begin
      r_flush <= 1'b1;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (w_xfer && r_last && w_empty) begin
          w_state_nxt = S_IDLE;
        end
`ifdef FFT_FEEDER_PAD_EN
        // Pad only once every buffered sample has left and the frame is genuinely partial.
        else if (r_flush && w_empty && !w_wr && (r_idx != '0) && !(r_valid && r_last)) begin
          w_state_nxt = S_PAD;
        end
`endif
      end
`ifdef FFT_FEEDER_PAD_EN
      S_PAD: begin
        if (w_xfer && r_last) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sample_ready = ~i_rst & ~w_full;
    w_rd           = 1'b0;
    w_load         = 1'b0;
    w_load_word    = 32'h0;
    case (r_state)
      S_STREAM: begin
        w_rd        = w_out_free & ~w_empty;
        w_load      = w_out_free & ~w_empty;
        w_load_word = {16'h0000, r_mem[r_rd_ptr[AW-1:0]]};
      end
`ifdef FFT_FEEDER_PAD_EN
      S_PAD: begin
        w_sample_ready = 1'b0;
        w_load         = w_out_free & ~(w_xfer & r_last);
      end
`endif
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= io_bus.i_sample;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_data       <= 32'h0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_load_word;
        r_last  <= (w_load_idx == LAST_IDX);
      end else if (w_xfer) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      if (w_xfer) r_idx <= r_idx + IW'(1);
      r_frame_done <= w_xfer & r_last;
    end
  end

  assign io_bus.o_sample_ready = w_sample_ready;
  assign io_bus.o_data         = r_data;
  assign io_bus.o_data_valid   = r_valid;
  assign io_bus.o_last         = r_last;
  assign io_bus.o_frame_done   = r_frame_done;
  assign io_bus.o_busy         = (r_idx != '0) | ~w_empty | r_valid;
  assign o_dbg_state           = r_state;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with FRAME_LEN=8, FIFO_DEPTH=16; expectations adapt to FFT_FEEDER_PAD_EN.
`timescale 1ns/1ps
module tb_fft_frame_feeder;
  localparam int FRAME_LEN  = 8;
  localparam int FIFO_DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int checks     = 0;
  int failures   = 0;
  int cyc_cnt    = 0;
  int xfer_cnt   = 0;
  int fd_cnt     = 0;
  int max_streak = 0;
  int frame_pos  = 0;
  logic [32:0] exp_q[$];

  fft_frame_feeder_if u_if ();

  fft_frame_feeder #(
    .FRAME_LEN (FRAME_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .io_bus     (u_if.master),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard model: each pushed word carries its own expected last flag
  task automatic exp_push(input logic [15:0] s);
    exp_q.push_back({(frame_pos == FRAME_LEN - 1), 16'h0000, s});
    frame_pos = (frame_pos + 1) % FRAME_LEN;
  endtask

  task automatic monitor_loop();
    logic        prev_stall = 1'b0;
    logic        prev_xfer  = 1'b0;
    logic        exp_fd     = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    logic [32:0] exp_w;
    logic        xfer;
    int          streak     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_xfer  = 1'b0;
        exp_fd     = 1'b0;
      end else begin
        chk("frame_done", 33'(u_if.o_frame_done), 33'(exp_fd));
        if (u_if.o_frame_done === 1'b1) fd_cnt++;
        if (prev_stall) begin
          chk("hold_valid", 33'(u_if.o_data_valid), 33'd1);
          chk("hold_data", 33'(u_if.o_data), 33'(prev_data));
        end
        xfer   = (u_if.o_data_valid === 1'b1) && u_if.i_data_ready;
        exp_fd = 1'b0;
        if (xfer) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_word observed=%h expected=none", {u_if.o_last, u_if.o_data});
          end else begin
            exp_w  = exp_q.pop_front();
            chk("word", {u_if.o_last, u_if.o_data}, exp_w);
            exp_fd = exp_w[32];
          end
          xfer_cnt++;
          streak = prev_xfer ? streak + 1 : 1;
          if (streak > max_streak) max_streak = streak;
        end
        prev_xfer  = xfer;
        prev_stall = (u_if.o_data_valid === 1'b1) && !u_if.i_data_ready;
        prev_data  = u_if.o_data;
      end
    end
  endtask

  // drivers
  task automatic send_burst(input logic [15:0] base, input int n);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < 200) begin
      u_if.i_sample       = base + 16'(sent);
      u_if.i_sample_valid = 1'b1;
      if (u_if.o_sample_ready) begin
        exp_push(u_if.i_sample);
        sent++;
      end
      cyc();
      guard++;
    end
    u_if.i_sample_valid = 1'b0;
    chk("burst_sent", 33'(sent), 33'(n));
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || u_if.o_data_valid) && n < max_cyc) begin
      cyc();
      n++;
    end
    chk({tag, "_drained"}, 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    int acc;
    int fd0;
    int xc0;
`ifdef FFT_FEEDER_PAD_EN
    int pad_seen;
`endif
    u_if.i_sample       = 16'h0;
    u_if.i_sample_valid = 1'b0;
    u_if.i_flush        = 1'b0;
    u_if.i_data_ready   = 1'b0;
    fork
      monitor_loop();
    join_none

    // reset
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_valid", 33'(u_if.o_data_valid), 33'd0);
    chk("rst_data", 33'(u_if.o_data), 33'd0);
    chk("rst_last", 33'(u_if.o_last), 33'd0);
    chk("rst_fdone", 33'(u_if.o_frame_done), 33'd0);
    chk("rst_busy", 33'(u_if.o_busy), 33'd0);
    chk("rst_sready", 33'(u_if.o_sample_ready), 33'd0);
    rst = 1'b0;
    #1;
    chk("rel_sready", 33'(u_if.o_sample_ready), 33'd1);

    // single frame, latency of the first word
    u_if.i_data_ready = 1'b1;
    fd0 = fd_cnt;
    max_streak = 0;
    for (int i = 0; i < 8; i++) begin
      u_if.i_sample       = 16'(i + 1);
      u_if.i_sample_valid = 1'b1;
      exp_push(16'(i + 1));
      cyc();
      if (i == 1) chk("t1_lat_n1_valid", 33'(u_if.o_data_valid), 33'd0);
      if (i == 2) begin
        chk("t1_lat_n2_valid", 33'(u_if.o_data_valid), 33'd1);
        chk("t1_lat_n2_data", 33'(u_if.o_data), 33'h0_0000_0001);
      end
    end
    u_if.i_sample_valid = 1'b0;
    drain("t1", 40);
    cyc();
    cyc();
    chk("t1_busy", 33'(u_if.o_busy), 33'd0);
    chk("t1_streak", 33'(max_streak), 33'd8);
    chk("t1_fd_count", 33'(fd_cnt - fd0), 33'd1);

    // backpressure: 16 in the FIFO plus 1 in the output register
    u_if.i_data_ready = 1'b0;
    fd0 = fd_cnt;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      u_if.i_sample_valid = (acc < 20);
      u_if.i_sample       = 16'h0100 + 16'(acc);
      if (u_if.i_sample_valid && u_if.o_sample_ready) begin
        exp_push(u_if.i_sample);
        acc++;
      end
      cyc();
    end
    chk("t2_accepted", 33'(acc), 33'd17);
    chk("t2_sready_low", 33'(u_if.o_sample_ready), 33'd0);
    chk("t2_frozen_data", 33'(u_if.o_data), 33'h0_0000_0100);
    chk("t2_busy", 33'(u_if.o_busy), 33'd1);
    u_if.i_sample_valid = 1'b0;
    u_if.i_data_ready   = 1'b1;
    drain("t2a", 60);
    send_burst(16'h0200, 7);
    drain("t2b", 40);
    cyc();
    chk("t2_fd_count", 33'(fd_cnt - fd0), 33'd3);

    // back-to-back frames without a bubble
    fd0 = fd_cnt;
    max_streak = 0;
    send_burst(16'h0300, 16);
    drain("t3", 40);
    cyc();
    chk("t3_streak", 33'(max_streak), 33'd16);
    chk("t3_fd_count", 33'(fd_cnt - fd0), 33'd2);
    chk("t3_busy", 33'(u_if.o_busy), 33'd0);

    // flush while idle with nothing buffered
    xc0 = xfer_cnt;
    u_if.i_flush = 1'b1;
    cyc();
    u_if.i_flush = 1'b0;
    repeat (6) cyc();
    chk("t4_busy", 33'(u_if.o_busy), 33'd0);
    chk("t4_valid", 33'(u_if.o_data_valid), 33'd0);
    chk("t4_no_words", 33'(xfer_cnt - xc0), 33'd0);

    // partial frame then flush
    fd0 = fd_cnt;
    send_burst(16'h7FFF, 1);
    send_burst(16'h8000, 1);
    send_burst(16'h0010, 1);
    u_if.i_flush = 1'b1;
    cyc();
    u_if.i_flush = 1'b0;
`ifdef FFT_FEEDER_PAD_EN
    repeat (5) exp_push(16'h0000);
    pad_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (dbg_state == 2'd2) begin
        pad_seen++;
        chk("t5_pad_sready", 33'(u_if.o_sample_ready), 33'd0);
      end
      cyc();
    end
    drain("t5", 40);
    cyc();
    chk("t5_pad_seen", 33'(pad_seen != 0), 33'd1);
    chk("t5_fd_count", 33'(fd_cnt - fd0), 33'd1);
    chk("t5_busy", 33'(u_if.o_busy), 33'd0);
`else
    drain("t5", 40);
    repeat (4) cyc();
    chk("t5_nopad_busy", 33'(u_if.o_busy), 33'd1);
    chk("t5_nopad_valid", 33'(u_if.o_data_valid), 33'd0);
    chk("t5_nopad_fd", 33'(fd_cnt - fd0), 33'd0);
    send_burst(16'h0400, 5);
    drain("t5b", 40);
    cyc();
    chk("t5_fd_count", 33'(fd_cnt - fd0), 33'd1);
    chk("t5_busy", 33'(u_if.o_busy), 33'd0);
`endif

    // reset after 5 words of a frame
    fd0 = fd_cnt;
    u_if.i_data_ready = 1'b0;
    send_burst(16'h0500, 8);
    chk("t6_loaded", 33'(u_if.o_data_valid), 33'd1);
    u_if.i_data_ready = 1'b1;
    repeat (5) cyc();
    u_if.i_data_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    frame_pos = 0;
    cyc();
    chk("t6_rst_valid", 33'(u_if.o_data_valid), 33'd0);
    chk("t6_rst_data", 33'(u_if.o_data), 33'd0);
    chk("t6_rst_last", 33'(u_if.o_last), 33'd0);
    chk("t6_rst_fdone", 33'(u_if.o_frame_done), 33'd0);
    chk("t6_rst_busy", 33'(u_if.o_busy), 33'd0);
    chk("t6_rst_sready", 33'(u_if.o_sample_ready), 33'd0);
    chk("t6_rst_state", 33'(dbg_state), 33'd0);
    rst = 1'b0;
    cyc();
    u_if.i_data_ready = 1'b1;
    send_burst(16'h0600, 8);
    drain("t6", 40);
    cyc();
    chk("t6_fd_count", 33'(fd_cnt - fd0), 33'd1);
    chk("t6_busy", 33'(u_if.o_busy), 33'd0);

    // report
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_frame_feeder.md
# fft_frame_feeder

Source-side frame feeder for the FFT datapath: accepts real 16-bit samples from the capture or host side, buffers them in a small FIFO, packs each into the 32-bit complex word the FFT input stream expects, and drives that stream with a valid/ready handshake. Frames are counted so that exactly `FRAME_LEN` words leave per frame, with a last-word marker and a frame-done pulse. A flush request completes a partial frame with zero padding. Sits directly upstream of the FFT computer's `i_data` / `i_data_valid` / `o_data_ready` input.

## Interface
- `FRAME_LEN`, 1024, words per FFT frame; power of two, 8..65536.
- `FIFO_DEPTH`, 16, sample FIFO entries; power of two, ≥2.
- `i_clk`  in  1  single clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_sample`  in  16  signed real sample.
- `i_sample_valid`  in  1  sample present.
- `o_sample_ready`  out  1  FIFO can accept; write occurs when valid & ready.
- `i_flush`  in  1  single-cycle request to complete the current partial frame.
- `o_data`  out  32  packed word: [31:16] imag = 16'h0000, [15:0] real = sample.
- `o_data_valid`  out  1  `o_data` valid.
- `i_data_ready`  in  1  downstream accepts; transfer when valid & ready.
- `o_last`  out  1  high with the word at frame index `FRAME_LEN-1`.
- `o_frame_done`  out  1  one-cycle pulse after the last word of a frame transfers.
- `o_busy`  out  1  high when frame index ≠ 0, FIFO not empty, or output register valid.

## Operation
- FIFO: `FIFO_DEPTH` entries, pointer width log2(depth)+1 with wrap bit; full and empty from pointer compare. Simultaneous write and read when full is allowed: the read frees the slot in the same cycle, so `o_sample_ready` = !full | (read this cycle) is not used. `o_sample_ready` = !full only, to keep the path registered.
- Output register: one stage holding `o_data`, `o_data_valid`, and `o_last`. Loads when empty or when the current word transfers. While valid and not accepted, contents stay frozen.
- Frame index: counter of width log2(`FRAME_LEN`), incremented on each output transfer, wraps to 0 after `FRAME_LEN-1`. `o_last` = (index of loaded word == `FRAME_LEN-1`).
- FSM:
  - `IDLE`: index 0, nothing pending. Goes to `STREAM` on the first FIFO word.
  - `STREAM`: the output register loads from the FIFO. On the last-word transfer, goes to `IDLE` if the FIFO is empty, else stays in `STREAM`. If the flush flag is set and the FIFO is empty with index ≠ 0, goes to `PAD`.
  - `PAD`: the output register loads 32'h0 words. `o_sample_ready` is forced 0. Goes to `IDLE` after the last-word transfer.
- Flush flag: sticky. Set by `i_flush` when index ≠ 0 or data is pending. Cleared on entry to `IDLE`. `i_flush` in `IDLE` with the FIFO empty is ignored. `i_flush` in `PAD` has no effect. Samples already in the FIFO are always sent before padding starts.

## Timing
- Reset: `o_data`=0, `o_data_valid`=0, `o_last`=0, `o_frame_done`=0, `o_busy`=0, `o_sample_ready`=0 while `i_rst` is high. FIFO is emptied, index=0, flush flag=0, state `IDLE`.
- First cycle after reset release: `o_sample_ready`=1.
- Latency: a sample written at edge N appears on `o_data` with `o_data_valid`=1 after edge N+2 (FIFO write, then output-register load), given the output is free.
- Throughput: one word per cycle sustained while `i_data_ready`=1 and the FIFO is non-empty.
- `o_frame_done` is asserted in the cycle after the edge at which the `o_last` word transferred.
- `o_data_valid`, once high, never drops until the word transfers.
- Reset mid-frame discards the FIFO, the output word, and the frame position. No padding or `o_frame_done` is produced.

## Configuration
- `FFT_FEEDER_PAD_EN` defined: flush and `PAD` behaviour as above.
- `FFT_FEEDER_PAD_EN` undefined:
  - `i_flush` is ignored, and the flush flag and `PAD` state are not built.
  - Partial frames wait for further samples.
  - All other behaviour is identical.

## Test plan
- Reset, then write 8 samples 0x0001..0x0008 with `FRAME_LEN`=8 and `i_data_ready`=1 → words 0x00000001..0x00000008 on consecutive cycles; first word 2 cycles after the first write; `o_last` on 0x00000008; `o_frame_done` pulse on the next cycle; `o_busy` low afterwards.
- Backpressure: `i_data_ready`=0 with 20 samples offered, `FIFO_DEPTH`=16 → `o_sample_ready` falls after 17 accepted (16 in the FIFO plus 1 in the output register); `o_data` stays frozen at the first word; release → all 17 words emerge in order, none lost.
- Flush (`FFT_FEEDER_PAD_EN` defined): 3 samples 0x7FFF, 0x8000, 0x0010, then `i_flush` → those 3 words followed by 5 words of 0x00000000; `o_last` on the 8th word; `o_sample_ready`=0 during padding.
- Flush in `IDLE` with the FIFO empty → no output, `o_busy` stays 0. With the macro undefined, the 3-sample case produces 3 words and no padding.
- Back-to-back frames, 16 samples continuous with `FRAME_LEN`=8 → `o_last` on words 8 and 16, two `o_frame_done` pulses, no bubble between frames.
- Assert `i_rst` after 5 words of a frame → all outputs 0 on the next cycle; a new 8-sample burst forms a complete frame, with `o_last` on its 8th word.
